// File: rtl/mutative_tag_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mutative_tag_sram_ctrl
//  Purpose  : Single-port tag SRAM with lane write masks, a one-cycle read
//             latency and a self-clearing sweep. After reset, or on a clear
//             request, every entry is rewritten with INIT_VALUE, one address
//             per cycle. No accesses are accepted while a sweep is running.
//  Ports    : clk0     - clock (rising edge)
//             rst0_n   - asynchronous active-low reset
//             csb0     - active-low access request
//             web0     - active-low write select (1 = read)
//             wmask0   - per-lane write enables
//             addr0    - word address
//             din0     - write data
//             clear0   - request to re-initialise every entry
//             dout0    - read data; holds until the next accepted read
//             rvalid0  - one-cycle pulse when dout0 carries new read data
//             ready0   - high when an access or clear can be accepted
//  Revision : 1.0 - initial release
// ============================================================================
module mutative_tag_sram_ctrl #(
  parameter int                    DATA_WIDTH  = 21,
  parameter int                    ADDR_WIDTH  = 7,
  parameter int                    WMASK_WIDTH = 3,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
  input  logic                   clk0,
  input  logic                   rst0_n,
  input  logic                   csb0,
  input  logic                   web0,
  input  logic [WMASK_WIDTH-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0]  din0,
  input  logic                   clear0,
  output logic [DATA_WIDTH-1:0]  dout0,
  output logic                   rvalid0,
  output logic                   ready0
);

  localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;
  localparam int LANE_WIDTH = DATA_WIDTH / WMASK_WIDTH;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   sweep_addr;
  logic                    sweep_last;
  logic                    sweep_we;
  logic                    access;
  logic [DATA_WIDTH-1:0]   lane_bits;
  logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

  // Expand the lane enables into a per-bit write mask.
  for (genvar i = 0; i < WMASK_WIDTH; i++) begin : g_lane
    assign lane_bits[i*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{wmask0[i]}};
  end

  // Terminal compare ends the sweep; the counter then wraps to 0, which is
  // exactly the start address the next sweep needs.
  assign sweep_last = (sweep_addr == {ADDR_WIDTH{1'b1}});

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state <= CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready0    = 1'b0;
    sweep_we  = 1'b0;
    access    = 1'b0;
    case (state)
      CLEAR: begin
        // Clear requests here are ignored: the sweep neither restarts nor
        // extends.
        sweep_we = 1'b1;
        if (sweep_last) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        ready0 = 1'b1;
        // A clear beats a simultaneous access; the access is dropped.
        if (clear0) begin
          state_nxt = CLEAR;
        end else if (!csb0) begin
          access = 1'b1;
        end
      end
      default: begin
        state_nxt = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      sweep_addr <= '0;
    end else if (sweep_we) begin
      sweep_addr <= sweep_addr + ADDR_WIDTH'(1);
    end
  end

  // Storage has no reset. While reset is held the sweep repeatedly targets
  // address 0, which the post-reset sweep rewrites anyway.
  always_ff @(posedge clk0) begin
    if (sweep_we) begin
      mem[sweep_addr] <= INIT_VALUE;
    end else if (access && !web0) begin
      mem[addr0] <= (mem[addr0] & ~lane_bits) | (din0 & lane_bits);
    end
  end

  // A write completed on the previous edge is already in mem, so a read
  // directly behind it sees the merged word without any bypass.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      dout0   <= '0;
      rvalid0 <= 1'b0;
    end else begin
      rvalid0 <= access && web0;
      if (access && web0) begin
        dout0 <= mem[addr0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mutative_tag_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mutative_tag_sram_ctrl
//  Purpose  : Self-checking bench for mutative_tag_sram_ctrl. A default
//             instance is driven with directed and random traffic against a
//             word-array reference model; a second instance with 32-bit data,
//             16 entries and byte lanes runs a short directed sequence.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mutative_tag_sram_ctrl;

  localparam int DW    = 21;
  localparam int AW    = 7;
  localparam int MW    = 3;
  localparam int LW    = DW / MW;
  localparam int DEPTH = 1 << AW;

  logic          clk0   = 1'b0;
  logic          rst0_n = 1'b1;
  logic          csb0   = 1'b1;
  logic          web0   = 1'b1;
  logic [MW-1:0] wmask0 = '0;
  logic [AW-1:0] addr0  = '0;
  logic [DW-1:0] din0   = '0;
  logic          clear0 = 1'b0;
  logic [DW-1:0] dout0;
  logic          rvalid0;
  logic          ready0;

  logic          b_csb0   = 1'b1;
  logic          b_web0   = 1'b1;
  logic [3:0]    b_wmask0 = '0;
  logic [3:0]    b_addr0  = '0;
  logic [31:0]   b_din0   = '0;
  logic          b_clear0 = 1'b0;
  logic [31:0]   b_dout0;
  logic          b_rvalid0;
  logic          b_ready0;
  logic          done32   = 1'b0;

  mutative_tag_sram_ctrl u_dut (
    .clk0    (clk0),
    .rst0_n  (rst0_n),
    .csb0    (csb0),
    .web0    (web0),
    .wmask0  (wmask0),
    .addr0   (addr0),
    .din0    (din0),
    .clear0  (clear0),
    .dout0   (dout0),
    .rvalid0 (rvalid0),
    .ready0  (ready0)
  );

  mutative_tag_sram_ctrl #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (4),
    .WMASK_WIDTH (4)
  ) u_dut32 (
    .clk0    (clk0),
    .rst0_n  (rst0_n),
    .csb0    (b_csb0),
    .web0    (b_web0),
    .wmask0  (b_wmask0),
    .addr0   (b_addr0),
    .din0    (b_din0),
    .clear0  (b_clear0),
    .dout0   (b_dout0),
    .rvalid0 (b_rvalid0),
    .ready0  (b_ready0)
  );

  always #5 clk0 = ~clk0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: busy counts sweep cycles still to run (ready when 0).
  int            busy = DEPTH;
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] last_dout = '0;

  function automatic void model_step();
    if (!rst0_n) return;
    if (busy > 0) begin
      ref_mem[DEPTH - busy] = '0;
      busy--;
    end else if (clear0) begin
      busy = DEPTH;
    end else if (!csb0) begin
      if (web0) begin
        exp_q.push_back(ref_mem[addr0]);
      end else begin
        for (int i = 0; i < MW; i++) begin
          if (wmask0[i]) ref_mem[addr0][i*LW +: LW] = din0[i*LW +: LW];
        end
      end
    end
  endfunction

  task automatic cyc(input logic c, input logic w, input logic [MW-1:0] m,
                     input logic [AW-1:0] a, input logic [DW-1:0] d, input logic clr);
    csb0 = c; web0 = w; wmask0 = m; addr0 = a; din0 = d; clear0 = clr;
    @(posedge clk0);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b1, 1'b1, '0, '0, '0, 1'b0);
  endtask

  task automatic rnd(input int n, input int clr_range);
    repeat (n) cyc($urandom_range(0, 9) >= 7, 1'($urandom_range(0, 1)), MW'($urandom),
                   AW'($urandom_range(0, 15)), DW'($urandom),
                   $urandom_range(0, clr_range - 1) == 0);
  endtask

  task automatic do_reset(input int n);
    rst0_n = 1'b0;
    exp_q.delete();
    last_dout = '0;
    busy = DEPTH;
    idle(n);
    rst0_n = 1'b1;
  endtask

  // Monitor: ready0 follows the model, rvalid0 pulses exactly when a read
  // result is due, and dout0 carries the newest read result at all times.
  always @(negedge clk0) begin
    check("ready0", 32'(ready0), 32'(rst0_n && busy == 0));
    check("rvalid0", 32'(rvalid0), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) last_dout = exp_q.pop_front();
    check("dout0", 32'(dout0), 32'(last_dout));
  end

  // Second configuration: 16-cycle sweep and byte-lane merging.
  initial begin
    @(posedge rst0_n);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk0); #1;
      check("b_ready0_sweep", 32'(b_ready0), 32'(k == 16));
    end
    b_csb0 = 1'b0; b_web0 = 1'b0; b_wmask0 = 4'hF; b_addr0 = 4'd5; b_din0 = 32'hFFFF_FFFF;
    @(posedge clk0); #1;
    b_wmask0 = 4'b0010; b_din0 = 32'h0;
    @(posedge clk0); #1;
    b_web0 = 1'b1;
    @(posedge clk0); #1;
    b_csb0 = 1'b1;
    check("b_rvalid0_first", 32'(b_rvalid0), 32'h1);
    check("b_dout0_first", b_dout0, 32'hFFFF_00FF);
    b_csb0 = 1'b0; b_web0 = 1'b0; b_wmask0 = 4'b1001; b_din0 = 32'h1234_5678;
    @(posedge clk0); #1;
    check("b_rvalid0_on_write", 32'(b_rvalid0), 32'h0);
    check("b_dout0_hold", b_dout0, 32'hFFFF_00FF);
    b_web0 = 1'b1;
    @(posedge clk0); #1;
    b_csb0 = 1'b1;
    check("b_rvalid0_second", 32'(b_rvalid0), 32'h1);
    check("b_dout0_second", b_dout0, 32'h12FF_0078);
    done32 = 1'b1;
  end

  initial begin
    #1;
    do_reset(3);
    // Requests during the initial sweep must be dropped.
    rnd(DEPTH, 40);
    // Every entry reads as the init value.
    for (int a = 0; a < DEPTH; a++) cyc(1'b0, 1'b1, '0, AW'(a), '0, 1'b0);
    idle(2);
    // Lane merge on a single word.
    cyc(1'b0, 1'b0, 3'b111, 7'd5, 21'h1FFFFF, 1'b0);
    cyc(1'b0, 1'b0, 3'b010, 7'd5, 21'h000000, 1'b0);
    cyc(1'b0, 1'b1, '0, 7'd5, '0, 1'b0);
    idle(2);
    // Back-to-back reads after known writes.
    for (int a = 1; a <= 3; a++) cyc(1'b0, 1'b0, 3'b111, AW'(a), DW'($urandom), 1'b0);
    for (int a = 1; a <= 3; a++) cyc(1'b0, 1'b1, '0, AW'(a), '0, 1'b0);
    idle(3);
    // Clear wins over a simultaneous write.
    cyc(1'b0, 1'b0, 3'b111, 7'd9, 21'h0ABCDE, 1'b0);
    cyc(1'b0, 1'b0, 3'b111, 7'd9, 21'h155555, 1'b1);
    rnd(DEPTH, 20);
    cyc(1'b0, 1'b1, '0, 7'd9, '0, 1'b0);
    idle(2);
    // Reset in the middle of a sweep at address 60.
    cyc(1'b1, 1'b1, '0, '0, '0, 1'b1);
    idle(60);
    do_reset(2);
    rnd(DEPTH, 30);
    // Random traffic on a small address window for frequent same-address hits.
    rnd(800, 200);
    idle(DEPTH);
    for (int a = 0; a < DEPTH; a++) cyc(1'b0, 1'b1, '0, AW'(a), '0, 1'b0);
    idle(3);
    for (int k = 0; k < 100 && !done32; k++) idle(1);
    check("b_sequence_done", 32'(done32), 32'h1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
